pe_bitcol_array: RTL
====================

// Module: pe_bitcol_array
// PURPOSE
//  Parametrised bit-column processing element: NUM_BCE lanes, each a bit-column engine (BCE).
//  Each lane gates ACT_PER_BCE activations with one weight bit-column, then shifts and signs the sum.
//  Lane partials are reduced per a runtime mode (1, 2 or NUM_BCE results) and accumulated over a group of beats.
//  Group end is marked by in_last; valid/ready handshakes replace the per-lane done strobes.
// PARAMETERS
//  NUM_BCE      4   lane count; power of 2, >=2
//  ACT_PER_BCE  8   activations per lane (= weight bits per lane column)
//  ACT_W        8   activation width, unsigned
//  SHIFT_W      3   per-lane shift-offset width (shift 0..2^SHIFT_W-1)
//  ACC_W        32  accumulator width per result slot, signed two's complement
// PORTS
//  clk        in   1                          clock
//  rstn       in   1                          asynchronous active-low reset
//  in_valid   in   1                          beat valid
//  in_ready   out  1                          beat accepted when in_valid&in_ready
//  in_last    in   1                          final beat of the accumulation group
//  mode       in   2                          0: 1 result, 1: 2 results, 2: NUM_BCE results, 3: reserved (treated as 0)
//  acts       in   NUM_BCE*ACT_PER_BCE*ACT_W  lane i uses slice i
//  wcol       in   NUM_BCE*ACT_PER_BCE        weight bit-column, lane i uses slice i
//  wsign      in   1                          1: negate all lane partials this beat
//  shift      in   NUM_BCE*SHIFT_W            per-lane left shift
//  out_valid  out  1                          result valid
//  out_ready  in   1                          result consumed on out_valid&out_ready
//  result     out  NUM_BCE*ACC_W              slot k = bits [k*ACC_W +: ACC_W]; unused slots 0
//  ovf        out  1                          sticky overflow flag for the current group (0 unless PE_SAT_EN)
// BEHAVIOUR
//  Lane partial: p_i = (sum_j wcol[i][j] ? acts[i][j] : 0) << shift_i, negated if wsign; sign-extended to ACC_W.
//  Stage 1 (S1) registers all p_i on accept. Stage 2 reduces S1 per the latched mode and adds it into acc[].
//   mode0: slot0 += sum all lanes. mode1: slot0 += lanes [0,N/2), slot1 += [N/2,N). mode2: slot i += p_i.
//  Mode is latched at the first accepted beat of a group; later mode changes are ignored until the next group.
//  FSM: IDLE, ACC, FLUSH, OUT.
//   IDLE : in_ready=1; accept -> S1 load; ->FLUSH if in_last, else ->ACC.
//   ACC  : in_ready=1; S1 from the previous beat is added each cycle; accepted in_last -> FLUSH.
//   FLUSH: in_ready=0; last S1 added into acc; -> OUT.
//   OUT  : out_valid=1, in_ready=0; result/ovf held stable until out_ready; handshake clears acc, ovf, S1 -> IDLE.
//  Latency: out_valid rises 2 cycles after the in_last accept. A single-beat group occupies >=3 cycles.
//  In ACC, an idle cycle (in_valid=0) adds nothing; S1 valid bit gates the add.
//  Arithmetic: without PE_SAT_EN, acc wraps mod 2^ACC_W.
//  Reset (any time, incl. mid-group or in OUT): state=IDLE, acc=0, S1 cleared; in_ready=0 while rstn=0, 1 after release; out_valid=0, result=0, ovf=0.
// CONFIGURATION
//  PE_SAT_EN defined: each add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; ovf set sticky on any clamp in the group.
//  PE_SAT_EN undefined: wrap-around add; ovf tied 0.
// STRUCTURE
//  Package pe_pkg: mode enum (PE_MODE_ALL/HALF/LANE), FSM state enum, partial-width function.
//  Sub-module pe_bce_lane: combinational gate/sum/shift/sign for one lane; instantiated NUM_BCE times.
// TESTING
//  T1 mode0, N=4: 1 beat, all acts=1, wcol=0xFF each, shift=0, in_last -> result slot0=32, out_valid 2 cycles later.
//  T2 mode2: 3 beats acts=3, wcol lane i=(1<<i), shift=1, in_last on beat 3 -> slot i=18 for all i.
//  T3 mode1, wsign=1 on beat 2 of 2, equal beats -> both slots 0; mode toggled mid-group has no effect.
//  T4 out_ready held low 5 cycles in OUT: in_ready=0, result stable; in_valid ignored; release -> IDLE.
//  T5 ACC_W=12, repeat max partial 20 beats: wrap value without PE_SAT_EN; 2047 and ovf=1 with it.
//  T6 rstn low during ACC and during OUT -> all outputs 0 next edge; new group after release sums from 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and helpers for the bit-column processing element.
// Optional saturating accumulation is enabled by defining PE_SAT_EN.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_MODE_ALL  = 2'd0,
    PE_MODE_HALF = 2'd1,
    PE_MODE_LANE = 2'd2
  } pe_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } pe_state_e;

  // Signed lane partial: gated sum, max left shift, sign bit.
  function automatic int pe_part_w(int act_per, int act_w, int shift_w);
    return act_w + $clog2(act_per) + (1 << shift_w);
  endfunction

  function automatic pe_mode_e pe_mode_map(logic [1:0] m);
    pe_mode_e r;
    r = PE_MODE_ALL;
    if (m == 2'd1) r = PE_MODE_HALF;
    if (m == 2'd2) r = PE_MODE_LANE;
    return r;
  endfunction

endpackage

// File: rtl/pe_bce_lane.sv
// One bit-column engine: gate activations by weight bits, sum,
// shift and optionally negate. Purely combinational.
module pe_bce_lane
  import pe_pkg::*;
#(
  parameter int ACT_PER_BCE = 8,
  parameter int ACT_W       = 8,
  parameter int SHIFT_W     = 3,
  parameter int PW          = pe_part_w(ACT_PER_BCE, ACT_W, SHIFT_W)
) (
  input  logic [ACT_PER_BCE*ACT_W-1:0] acts,
  input  logic [ACT_PER_BCE-1:0]       wcol,
  input  logic                         wsign,
  input  logic [SHIFT_W-1:0]           shift,
  output logic signed [PW-1:0]         part
);

  localparam int SUMW = ACT_W + $clog2(ACT_PER_BCE);

  logic [SUMW-1:0] sum;
  logic [PW-2:0]   mag;

  always_comb begin
    sum = '0;
    for (int j = 0; j < ACT_PER_BCE; j++) begin
      if (wcol[j]) sum = sum + SUMW'(acts[j*ACT_W +: ACT_W]);
    end
    mag  = (PW-1)'(sum) << shift;
    part = wsign ? -$signed({1'b0, mag})
                 : $signed({1'b0, mag});
  end

endmodule

// File: rtl/pe_bitcol_array.sv
// NUM_BCE-lane bit-column PE with mode-reduced group accumulation.
// Define PE_SAT_EN for saturating adds with a sticky ovf flag.
module pe_bitcol_array
  import pe_pkg::*;
#(
  parameter int NUM_BCE     = 4,
  parameter int ACT_PER_BCE = 8,
  parameter int ACT_W       = 8,
  parameter int SHIFT_W     = 3,
  parameter int ACC_W       = 32
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic [1:0]                         mode,
  input  logic [NUM_BCE*ACT_PER_BCE*ACT_W-1:0] acts,
  input  logic [NUM_BCE*ACT_PER_BCE-1:0]     wcol,
  input  logic                               wsign,
  input  logic [NUM_BCE*SHIFT_W-1:0]         shift,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_BCE*ACC_W-1:0]           result,
  output logic                               ovf
);

  localparam int PW   = pe_part_w(ACT_PER_BCE, ACT_W, SHIFT_W);
  localparam int RW   = PW + $clog2(NUM_BCE);
  localparam int HALF = NUM_BCE / 2;

  pe_state_e state;
  pe_mode_e  mode_q;

  logic signed [PW-1:0]    part    [NUM_BCE];
  logic signed [PW-1:0]    s1      [NUM_BCE];
  logic                    s1_vld;
  logic signed [RW-1:0]    red     [NUM_BCE];
  logic signed [ACC_W-1:0] acc     [NUM_BCE];
  logic signed [ACC_W-1:0] acc_nxt [NUM_BCE];
  logic                    accept;
  logic                    done;

  assign in_ready  = rstn & ((state == ST_IDLE) | (state == ST_ACC));
  assign out_valid = (state == ST_OUT);
  assign accept    = in_valid & in_ready;
  assign done      = out_valid & out_ready;

  for (genvar i = 0; i < NUM_BCE; i++) begin : g_lane
    pe_bce_lane #(
      .ACT_PER_BCE (ACT_PER_BCE),
      .ACT_W       (ACT_W),
      .SHIFT_W     (SHIFT_W),
      .PW          (PW)
    ) u_lane (
      .acts  (acts[i*ACT_PER_BCE*ACT_W +: ACT_PER_BCE*ACT_W]),
      .wcol  (wcol[i*ACT_PER_BCE +: ACT_PER_BCE]),
      .wsign (wsign),
      .shift (shift[i*SHIFT_W +: SHIFT_W]),
      .part  (part[i])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_BCE; k++) red[k] = '0;
    for (int i = 0; i < NUM_BCE; i++) begin
      unique case (mode_q)
        PE_MODE_HALF: begin
          if (i < HALF) red[0] = red[0] + RW'(s1[i]);
          else          red[1] = red[1] + RW'(s1[i]);
        end
        PE_MODE_LANE: red[i] = RW'(s1[i]);
        default:      red[0] = red[0] + RW'(s1[i]);
      endcase
    end
  end

`ifdef PE_SAT_EN
  localparam int SW = ((RW > ACC_W) ? RW : ACC_W) + 1;
  localparam logic signed [SW-1:0] SAT_MAX =
    SW'((longint'(1) << (ACC_W-1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - 1;

  logic ovf_q;
  logic clamp;

  always_comb begin
    logic signed [SW-1:0] wide;
    clamp = 1'b0;
    for (int k = 0; k < NUM_BCE; k++) begin
      wide = SW'(acc[k]) + SW'(red[k]);
      if (wide > SAT_MAX) begin
        acc_nxt[k] = ACC_W'(SAT_MAX);
        clamp      = 1'b1;
      end else if (wide < SAT_MIN) begin
        acc_nxt[k] = ACC_W'(SAT_MIN);
        clamp      = 1'b1;
      end else begin
        acc_nxt[k] = ACC_W'(wide);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if (done) begin
      ovf_q <= 1'b0;
    end else if (s1_vld) begin
      ovf_q <= ovf_q | clamp;
    end
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    for (int k = 0; k < NUM_BCE; k++) begin
      acc_nxt[k] = acc[k] + ACC_W'(red[k]);
    end
  end

  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      mode_q <= PE_MODE_ALL;
      s1_vld <= 1'b0;
      for (int k = 0; k < NUM_BCE; k++) begin
        s1[k]  <= '0;
        acc[k] <= '0;
      end
    end else begin
      s1_vld <= accept;
      if (accept) begin
        for (int k = 0; k < NUM_BCE; k++) s1[k] <= part[k];
      end
      if (s1_vld) begin
        for (int k = 0; k < NUM_BCE; k++) acc[k] <= acc_nxt[k];
      end
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q <= pe_mode_map(mode);
            state  <= in_last ? ST_FLUSH : ST_ACC;
          end
        end
        ST_ACC: begin
          if (accept && in_last) state <= ST_FLUSH;
        end
        ST_FLUSH: state <= ST_OUT;
        default: begin
          if (out_ready) begin
            state  <= ST_IDLE;
            s1_vld <= 1'b0;
            for (int k = 0; k < NUM_BCE; k++) acc[k] <= '0;
          end
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_BCE; k++) begin : g_res
    assign result[k*ACC_W +: ACC_W] = out_valid ? acc[k] : '0;
  end

endmodule
